motoro_gate_drv: RTL
====================

Name: motoro_gate_drv

Overview:
- Parametrised N-phase gate-drive output stage; successor to the fixed 3-phase output/registering stage.
- Sits between the commutation/PWM core and the MOSFET pins.
- Registers and clamps the core's control inputs (start, inv/stop, frequency) and gates per-phase high/low requests with pwm and per-phase enables.
- Adds what the old stage lacked: dead-time insertion, a shoot-through guard, a latched fault shutdown, and per-pin polarity.

Parameters:
- NPH, 3, number of half-bridge phases.
- FREQ_W, 10, width of the frequency word.
- FREQ_MIN, 1000, lower clamp applied to the frequency word.
- DEAD_CYC, 8, dead-time length in clk cycles; must be >= 1.
- HI_INV, 0, XOR applied to every high-side pin.
- LO_INV, 1, XOR applied to every low-side pin (low-side driver is active-low).

Ports:
- clk  in  1  system clock, 10 MHz.
- nRst  in  1  asynchronous active-low reset.
- m3start  in  1  run request from host.
- m3invOrStop  in  1  direction/stop request from host.
- m3freq  in  FREQ_W  requested frequency word.
- m3start_o  out  1  registered m3start, to core.
- m3invOrStop_o  out  1  registered m3invOrStop, to core.
- m3freq_o  out  FREQ_W  registered, clamped frequency word, to core.
- pwm  in  1  PWM carrier from core.
- phH_i  in  NPH  per-phase high-side request from core.
- phL_i  in  NPH  per-phase low-side request from core.
- phEn  in  NPH  per-phase enable (quasi-static).
- faultIn  in  1  asynchronous external fault, active-high.
- faultClr  in  1  single-cycle fault-clear pulse.
- phH  out  NPH  high-side gate pins.
- phL  out  NPH  low-side gate pins.
- fault  out  1  latched fault status.
- shootErr  out  NPH  sticky per-phase illegal-request flag.
- dtBusy  out  NPH  phase is currently in dead time.

Behaviour:
- Reset (nRst low, asynchronous) drives these values:
  - m3start_o=0, m3invOrStop_o=0, m3freq_o=0.
  - All phases in OFF, so phH=HI_INV and phL=LO_INV on every bit (all transistors off).
  - fault=0, shootErr=0, dtBusy=0, sync flops=0.
- Input register, updated every clk:
  - m3start_o <= m3start; m3invOrStop_o <= m3invOrStop.
  - m3freq_o <= (m3freq > FREQ_MIN) ? m3freq : FREQ_MIN, unsigned compare. Equal-to-FREQ_MIN yields FREQ_MIN.
- Request register, one per phase p, updated every clk:
  - hreq = pwm & phH_i[p] & phEn[p] & ~fault.
  - lreq = pwm & phL_i[p] & phEn[p] & ~fault.
  - hreq and lreq both 1 is illegal: treated as OFF, and shootErr[p] is set. shootErr clears only on faultClr or reset.
- Per-phase FSM, one-hot states OFF, HI, LO, DEAD, with a down-counter of width clog2(DEAD_CYC+1). Transitions use the registered request:
  - OFF: hreq -> HI; lreq -> LO; otherwise stay.
  - HI: while hreq, stay; on any other request -> DEAD, counter loaded with DEAD_CYC-1.
  - LO: while lreq, stay; on any other request -> DEAD, counter loaded with DEAD_CYC-1.
  - DEAD: when counter==0, go to the state selected by the current request (HI, LO or OFF); otherwise decrement. DEAD always runs to completion, even if the request returns to the previous side.
- Output timing:
  - DEAD lasts exactly DEAD_CYC cycles with both devices off.
  - phH[p] = HI_q ^ HI_INV; phL[p] = LO_q ^ LO_INV; dtBusy[p] = DEAD_q. All are flop outputs, so no glitches.
  - Latency from pwm/phX_i to a pin with no dead time pending is 2 clk (request register + state register).
  - HI and LO are never simultaneously active; a bench assertion enforces this.
- Fault handling:
  - faultIn passes through a 2-flop synchroniser; synchronised high sets fault.
  - While fault=1, the requests are forced OFF, so active phases go through DEAD to OFF. First device-off is 2 clk after the synchronised edge, i.e. 4 clk from faultIn.
  - fault clears only on faultClr=1 while synchronised faultIn=0. faultClr while faultIn is still high is ignored.
  - If the set and clear conditions occur together, set wins.
- A phEn deassert mid-conduction behaves as a request drop: the phase goes to DEAD, then OFF.
- Mid-operation reset returns all phases to OFF immediately (asynchronous); no dead time is applied on reset.

Decomposition:
- Shared package motoro_pkg holds:
  - the phase-state one-hot encoding constants (ST_OFF, ST_HI, ST_LO, ST_DEAD);
  - default FREQ_MIN and DEAD_CYC;
  - the clog2 helper.
- One sub-module, motoro_phase_fsm: single-phase request register, FSM, dead counter and shootErr flag. It is instantiated NPH times via generate.
- The top holds the input register, clamp, fault synchroniser and fault latch.

Test Plan:
- Reset then release, no activity -> phH=3'b000, phL=3'b111, m3freq_o=0; one clk later m3freq_o=1000 with m3freq=0.
- m3freq=1001 -> m3freq_o=1001 after 1 clk; m3freq=1000 -> 1000; m3freq=5 -> 1000.
- Phase0: pwm=1, phEn=1, phH_i[0] held high -> phH[0]=1 exactly 2 clk later. Then swap to phL_i[0] -> phH[0]=0 at +2 clk, dtBusy[0]=1 for 8 clk, then phL[0]=0 (active-low on). No overlap cycle.
- phH_i[1]=phL_i[1]=1 with pwm=1 -> phase1 stays OFF and shootErr[1]=1. The flag persists after the requests drop and clears on faultClr.
- All phases conducting, faultIn pulsed high -> fault=1 3 clk later, all high-sides off at 4 clk, all phases OFF after dead time. faultClr while faultIn is high leaves fault=1; faultClr after faultIn is low clears it, and drive resumes through the normal 2-clk path.
- HI->request drop->HI again within DEAD -> full DEAD_CYC=8 cycles elapse before phH re-asserts. nRst asserted mid-DEAD -> all outputs go to off values immediately.

Source files
------------

// File: rtl/motoro_pkg.sv
// rtl/motoro_pkg.sv - shared encodings, defaults and helpers for the gate-drive stage
package motoro_pkg;

    localparam logic [3:0] ST_OFF  = 4'b0001;
    localparam logic [3:0] ST_HI   = 4'b0010;
    localparam logic [3:0] ST_LO   = 4'b0100;
    localparam logic [3:0] ST_DEAD = 4'b1000;

    localparam int FREQ_MIN_DEF = 1000;
    localparam int DEAD_CYC_DEF = 8;

    typedef enum logic [3:0] {
        PH_OFF  = ST_OFF,
        PH_HI   = ST_HI,
        PH_LO   = ST_LO,
        PH_DEAD = ST_DEAD
    } phase_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/motoro_gate_drv_if.sv
// rtl/motoro_gate_drv_if.sv - core-side control bus of the gate-drive stage
interface motoro_gate_drv_if #(
    parameter int NPH    = 3,
    parameter int FREQ_W = 10
);
    logic              m3start;
    logic              m3invOrStop;
    logic [FREQ_W-1:0] m3freq;
    logic              m3start_o;
    logic              m3invOrStop_o;
    logic [FREQ_W-1:0] m3freq_o;
    logic              pwm;
    logic [NPH-1:0]    phH_i;
    logic [NPH-1:0]    phL_i;
    logic [NPH-1:0]    phEn;

    modport master (
        output m3start, m3invOrStop, m3freq, pwm, phH_i, phL_i, phEn,
        input  m3start_o, m3invOrStop_o, m3freq_o
    );

    modport slave (
        input  m3start, m3invOrStop, m3freq, pwm, phH_i, phL_i, phEn,
        output m3start_o, m3invOrStop_o, m3freq_o
    );
endinterface

// File: rtl/motoro_phase_fsm.sv
// rtl/motoro_phase_fsm.sv - one half-bridge: request register, dead-time FSM, shoot-through flag
module motoro_phase_fsm
    import motoro_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter bit HI_INV   = 1'b0,
    parameter bit LO_INV   = 1'b1
) (
    input  logic clk,
    input  logic nRst,
    input  logic pwm,
    input  logic hIn,
    input  logic lIn,
    input  logic en,
    input  logic kill,
    input  logic faultClr,
    output logic phH,
    output logic phL,
    output logic shootErr,
    output logic dtBusy
);
    localparam int               CNT_W    = clog2(DEAD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYC - 1);

    logic         hRaw, lRaw;
    logic         hReq, lReq;
    phase_state_e state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;

    assign hRaw = pwm & hIn & en & ~kill;
    assign lRaw = pwm & lIn & en & ~kill;

    // A simultaneous high/low request is collapsed to OFF before the FSM sees it
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hReq     <= 1'b0;
            lReq     <= 1'b0;
            shootErr <= 1'b0;
        end else begin
            hReq <= hRaw & ~lRaw;
            lReq <= lRaw & ~hRaw;
            if (hRaw & lRaw)
                shootErr <= 1'b1;
            else if (faultClr)
                shootErr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= PH_OFF;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        unique case (state)
            PH_OFF: begin
                if (hReq)      stateNext = PH_HI;
                else if (lReq) stateNext = PH_LO;
            end
            PH_HI: begin
                if (!hReq) begin
                    stateNext = PH_DEAD;
                    cntNext   = CNT_LOAD;
                end
            end
            PH_LO: begin
                if (!lReq) begin
                    stateNext = PH_DEAD;
                    cntNext   = CNT_LOAD;
                end
            end
            PH_DEAD: begin
                // Dead time always runs out, even if the old side is requested again
                if (cnt == '0)
                    stateNext = hReq ? PH_HI : (lReq ? PH_LO : PH_OFF);
                else
                    cntNext = cnt - CNT_W'(1);
            end
            default: stateNext = PH_OFF;
        endcase
    end

    assign phH    = (|(state & ST_HI)) ^ HI_INV;
    assign phL    = (|(state & ST_LO)) ^ LO_INV;
    assign dtBusy = |(state & ST_DEAD);

endmodule

// File: rtl/motoro_gate_drv.sv
// rtl/motoro_gate_drv.sv - N-phase gate-drive output stage with clamp, dead time and fault latch
module motoro_gate_drv
    import motoro_pkg::*;
#(
    parameter int NPH      = 3,
    parameter int FREQ_W   = 10,
    parameter int FREQ_MIN = FREQ_MIN_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter bit HI_INV   = 1'b0,
    parameter bit LO_INV   = 1'b1
) (
    input  logic                  clk,
    input  logic                  nRst,
    motoro_gate_drv_if.slave      core,
    input  logic                  faultIn,
    input  logic                  faultClr,
    output logic [NPH-1:0]        phH,
    output logic [NPH-1:0]        phL,
    output logic                  fault,
    output logic [NPH-1:0]        shootErr,
    output logic [NPH-1:0]        dtBusy
);
    localparam logic [FREQ_W-1:0] FMIN = FREQ_W'(FREQ_MIN);

    logic faultMeta, faultSync;
    logic kill;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            core.m3start_o     <= 1'b0;
            core.m3invOrStop_o <= 1'b0;
            core.m3freq_o      <= '0;
        end else begin
            core.m3start_o     <= core.m3start;
            core.m3invOrStop_o <= core.m3invOrStop;
            core.m3freq_o      <= (core.m3freq > FMIN) ? core.m3freq : FMIN;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            faultMeta <= 1'b0;
            faultSync <= 1'b0;
            fault     <= 1'b0;
        end else begin
            faultMeta <= faultIn;
            faultSync <= faultMeta;
            if (faultSync)
                fault <= 1'b1;
            else if (faultClr)
                fault <= 1'b0;
        end
    end

    // Gating on the synchronised level too saves a cycle on the way to device-off
    assign kill = fault | faultSync;

    for (genvar p = 0; p < NPH; p++) begin : g_phase
        motoro_phase_fsm #(
            .DEAD_CYC (DEAD_CYC),
            .HI_INV   (HI_INV),
            .LO_INV   (LO_INV)
        ) u_phase (
            .clk      (clk),
            .nRst     (nRst),
            .pwm      (core.pwm),
            .hIn      (core.phH_i[p]),
            .lIn      (core.phL_i[p]),
            .en       (core.phEn[p]),
            .kill     (kill),
            .faultClr (faultClr),
            .phH      (phH[p]),
            .phL      (phL[p]),
            .shootErr (shootErr[p]),
            .dtBusy   (dtBusy[p])
        );
    end

endmodule
